fir_run_sequencer: RTL

- Controller that sequences one FIR_Filter pass for the delay beamformer.
- Sweeps the filter's input sample RAM address and asserts the filter run enable.
- Counts filter valid_out pulses to generate output RAM write addresses and write enables.
- After the pass, performs a host-requested readback sweep of the output RAM. It sits between the beamformer top-level control and FIR_Filter.

---
 rtl/fir_run_sequencer_pkg.sv | 21 ++
 rtl/fir_run_sequencer_if.sv | 32 +++
 rtl/fir_run_sequencer_delay.sv | 29 ++
 rtl/fir_run_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/fir_run_sequencer_pkg.sv
// Shared definitions for the FIR pass sequencer: state encoding and default geometry
// used by both the sequencer and the beamformer top.
package fir_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_DRAIN,
    ST_DONE,
    ST_READBACK
  } seq_state_e;

  localparam int unsigned SEQ_ADDR_W    = 11;
  localparam int unsigned SEQ_N_SAMPLES = 2048;

  // Width of a counter that must be able to hold the value n itself.
  function automatic int unsigned ctr_bits(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fir_run_sequencer_if.sv
// Signal bundle between the beamformer control/filter side (master) and the sequencer (slave).
interface fir_run_sequencer_if import fir_seq_pkg::*; #(
  parameter int unsigned ADDR_W = SEQ_ADDR_W
) ();

  logic              start;
  logic              rd_req;
  logic              filt_valid;
  logic              in_read;
  logic [ADDR_W-1:0] in_addr;
  logic              filt_run;
  logic              out_write_en;
  logic              out_read_en;
  logic [ADDR_W-1:0] out_addr;
  logic              rd_valid;
  logic              busy;
  logic              done;
  logic              timeout_err;

  modport master (
    output start, rd_req, filt_valid,
    input  in_read, in_addr, filt_run, out_write_en, out_read_en,
           out_addr, rd_valid, busy, done, timeout_err
  );

  modport slave (
    input  start, rd_req, filt_valid,
    output in_read, in_addr, filt_run, out_write_en, out_read_en,
           out_addr, rd_valid, busy, done, timeout_err
  );

endinterface

// File: rtl/fir_run_sequencer_delay.sv
// Fixed-depth 1-bit delay line with async active-low reset; depth 0 is a wire.
module seq_delay_line #(
  parameter int unsigned DEPTH = 1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  if (DEPTH == 0) begin : g_wire
    assign q_o = d_i;
  end else if (DEPTH == 1) begin : g_one
    logic sr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= 1'b0;
      else         sr_q <= d_i;
    end
    assign q_o = sr_q;
  end else begin : g_many
    logic [DEPTH-1:0] sr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else         sr_q <= {sr_q[DEPTH-2:0], d_i};
    end
    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/fir_run_sequencer.sv
// Sequences one FIR_Filter pass: input sweep, output write capture, drain timeout
// and a host-requested readback sweep of the output RAM.
module fir_run_sequencer import fir_seq_pkg::*; #(
  parameter int unsigned ADDR_W        = SEQ_ADDR_W,
  parameter int unsigned N_SAMPLES     = SEQ_N_SAMPLES,
  parameter int unsigned DRAIN_TIMEOUT = 256,
  parameter int unsigned RD_LAT        = 1
) (
  input  logic clk,
  input  logic rst,
  fir_run_sequencer_if.slave bus
);

  localparam int unsigned CW = ADDR_W + 1;
  localparam int unsigned IW = ctr_bits(DRAIN_TIMEOUT);
  localparam logic [CW-1:0] N_LAST = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] N_FULL = CW'(N_SAMPLES);
  localparam logic [IW-1:0] IDLE_LIMIT = IW'(DRAIN_TIMEOUT);

  seq_state_e    state_q;
  logic [CW-1:0] in_cnt_q;
  logic [CW-1:0] wr_cnt_q;
  logic [CW-1:0] rd_cnt_q;
  logic [IW-1:0] idle_q;
  logic          done_q;
  logic          terr_q;

  logic          st_feed, st_drain, st_rb;
  logic          wr_accept;
  logic [CW-1:0] wr_cnt_d;
  logic [IW-1:0] idle_d;

  always_comb begin
    st_feed   = (state_q == ST_FEED);
    st_drain  = (state_q == ST_DRAIN);
    st_rb     = (state_q == ST_READBACK);
    wr_accept = (st_feed || st_drain) && bus.filt_valid && (wr_cnt_q < N_FULL);
    wr_cnt_d  = wr_cnt_q + CW'(wr_accept);
    idle_d    = bus.filt_valid ? '0 : idle_q + IW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      in_cnt_q <= '0;
      wr_cnt_q <= '0;
      rd_cnt_q <= '0;
      idle_q   <= '0;
      done_q   <= 1'b0;
      terr_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_q  <= ST_FEED;
            in_cnt_q <= '0;
            wr_cnt_q <= '0;
            idle_q   <= '0;
            done_q   <= 1'b0;
            terr_q   <= 1'b0;
          end else if (state_q == ST_DONE && bus.rd_req) begin
            state_q  <= ST_READBACK;
            rd_cnt_q <= '0;
          end
        end

        // An early-finishing filter still lets the input sweep complete; the
        // write-count check happens on the last FEED cycle.
        ST_FEED: begin
          wr_cnt_q <= wr_cnt_d;
          if (in_cnt_q == N_LAST) begin
            idle_q <= '0;
            if (wr_cnt_d == N_FULL) begin
              state_q <= ST_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ST_DRAIN;
            end
          end else begin
            in_cnt_q <= in_cnt_q + CW'(1);
          end
        end

        ST_DRAIN: begin
          wr_cnt_q <= wr_cnt_d;
          idle_q   <= idle_d;
          if (wr_cnt_d == N_FULL) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (idle_d == IDLE_LIMIT) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            terr_q  <= 1'b1;
          end
        end

        ST_READBACK: begin
          if (rd_cnt_q == N_LAST) state_q <= ST_DONE;
          else                    rd_cnt_q <= rd_cnt_q + CW'(1);
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.in_read      = st_feed;
  assign bus.filt_run     = st_feed || st_drain;
  assign bus.in_addr      = in_cnt_q[ADDR_W-1:0];
  assign bus.out_write_en = wr_accept;
  assign bus.out_read_en  = st_rb;
  assign bus.out_addr     = st_rb ? rd_cnt_q[ADDR_W-1:0] : wr_cnt_q[ADDR_W-1:0];
  assign bus.busy         = st_feed || st_drain || st_rb;
  assign bus.done         = done_q;
  assign bus.timeout_err  = terr_q;

  seq_delay_line #(.DEPTH(RD_LAT)) u_rd_valid (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (st_rb),
    .q_o    (bus.rd_valid)
  );

endmodule
